// File: rtl/aes_hmac_out_collector_pkg.sv
// Shared types and defaults for the AES/HMAC output collector.
// Holds the frame FSM state enum, size defaults and the byte-lane insert helper.
package aes_hmac_out_collector_pkg;

  localparam int CIPHER_BYTES_D = 16;
  localparam int TAG_BYTES_D    = 32;
  localparam int MAX_GAP_D      = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CIPHER,
    S_GAP,
    S_TAG,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [7:0] lane_next(
    input logic [7:0]  cur,
    input logic [7:0]  din,
    input logic        we,
    input logic [7:0]  idx,
    input int unsigned lane
  );
    return (we && idx == lane[7:0]) ? din : cur;
  endfunction

endpackage

// File: rtl/aes_hmac_out_collector_byte_packer.sv
// Little-endian byte packer: writes din into byte lane idx when we is high.
// Ports: clk, rst_n, we, idx, din in; data out (WIDTH bits, held between writes).
module byte_packer
  import aes_hmac_out_collector_pkg::*;
#(
  parameter int WIDTH = 128,
  localparam int NB   = WIDTH / 8,
  localparam int IW   = $clog2(NB)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        data[8*k +: 8] <= lane_next(data[8*k +: 8], din, we,
                                    8'(idx), unsigned'(k));
      end
    end
  end

endmodule

// File: rtl/aes_hmac_out_collector.sv
// Collects a cipher burst and HMAC tag burst, checks tag against exp_r.
// Ports: clk, rst_n, i_data/i_valid stream, i_exp_tag/i_exp_load, i_ack; o_cipher, o_tag, o_done, o_match, o_err.
module aes_hmac_out_collector
  import aes_hmac_out_collector_pkg::*;
#(
  parameter int CIPHER_BYTES = CIPHER_BYTES_D,
  parameter int TAG_BYTES    = TAG_BYTES_D,
  parameter int MAX_GAP      = MAX_GAP_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                i_data,
  input  logic                      i_valid,
  input  logic [TAG_BYTES*8-1:0]    i_exp_tag,
  input  logic                      i_exp_load,
  input  logic                      i_ack,
  output logic [CIPHER_BYTES*8-1:0] o_cipher,
  output logic [TAG_BYTES*8-1:0]    o_tag,
  output logic                      o_done,
  output logic                      o_match,
  output logic                      o_err
);

  localparam int CW  = $clog2(TAG_BYTES);
  localparam int CIW = $clog2(CIPHER_BYTES);
  localparam int GW  = $clog2(MAX_GAP + 1);
  localparam int TW  = TAG_BYTES * 8;

  localparam logic [CW-1:0] C_LAST = CW'(CIPHER_BYTES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TAG_BYTES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(MAX_GAP - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] exp_r;

  logic           c_we;
  logic           t_we;
  logic [CIW-1:0] c_idx;
  logic [CW-1:0]  t_idx;
  logic           match_now;

  // First byte of each burst is accepted in the state before the burst.
  assign c_we  = i_valid && (state == S_IDLE || state == S_CIPHER);
  assign t_we  = i_valid && (state == S_GAP || state == S_TAG);
  assign c_idx = (state == S_IDLE) ? '0 : cnt[CIW-1:0];
  assign t_idx = (state == S_GAP) ? '0 : cnt;

  // Last tag byte is still on i_data, not yet in the packer.
  assign match_now = ({i_data, o_tag[TW-9:0]} == exp_r);

  byte_packer #(.WIDTH(CIPHER_BYTES*8)) u_cipher (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (c_we),
    .idx   (c_idx),
    .din   (i_data),
    .data  (o_cipher)
  );

  byte_packer #(.WIDTH(TW)) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (t_we),
    .idx   (t_idx),
    .din   (i_data),
    .data  (o_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= '0;
    end else if (i_exp_load) begin
      exp_r <= i_exp_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      o_done  <= 1'b0;
      o_match <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_valid) begin
            cnt   <= CW'(1);
            state <= S_CIPHER;
          end
        end
        S_CIPHER: begin
          if (!i_valid) begin
            o_err <= 1'b1;
            state <= S_ERR;
          end else if (cnt == C_LAST) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (i_valid) begin
            cnt   <= CW'(1);
            state <= S_TAG;
          end else if (gap_cnt == G_LAST) begin
            o_err <= 1'b1;
            state <= S_ERR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_TAG: begin
          if (!i_valid) begin
            o_err <= 1'b1;
            state <= S_ERR;
          end else if (cnt == T_LAST) begin
            o_done  <= 1'b1;
            o_match <= match_now;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (i_ack) begin
            o_done  <= 1'b0;
            o_match <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_ERR: begin
          if (i_ack) begin
            o_err <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
